// File: rtl/sar_conv_sequencer_if.sv
// Conversion handshake and result FIFO read port
// for the SAR conversion sequencer.
interface sar_conv_sequencer_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              go;
  logic              valid;
  logic [DATA_W-1:0] result;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;

  modport master (
    output go,
    input  valid,
    input  result,
    input  rd_en,
    output rd_data,
    output empty,
    output full,
    output count
  );

  modport slave (
    input  go,
    output valid,
    output result,
    output rd_en,
    input  rd_data,
    input  empty,
    input  full,
    input  count
  );
endinterface

// File: rtl/sar_conv_sequencer.sv
// Host-side SAR conversion sequencer: trigger timer,
// go/valid FSM with timeout, FWFT result FIFO.
module sar_conv_sequencer #(
  parameter int DATA_W     = 8,
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 32,
  parameter int GAP        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                single,
  input  logic                clr_err,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err,
  sar_conv_sequencer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [PERIOD_W-1:0] P_ONE  = 1;
  localparam logic [TW-1:0]       T_ONE  = 1;
  localparam logic [TW-1:0]       T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]       G_ONE  = 1;
  localparam logic [GW-1:0]       G_LAST = GW'(GAP - 1);
  localparam logic [AW-1:0]       A_ONE  = 1;
  localparam logic [CW-1:0]       C_ONE  = 1;
  localparam logic [CW-1:0]       C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAP,
    S_GAP
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic                trig;
  logic                req;
  logic                pending;
  logic                go_r;
  logic [TW-1:0]       tcnt;
  logic [GW-1:0]       gcnt;
  logic [DATA_W-1:0]   cap;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       cnt;
  logic                wr;
  logic                fifo_full;
  logic                do_rd;
  logic                do_wr;
  logic                drop;

  // A period of zero fires on every enabled cycle.
  assign trig = enable &&
                ((period == '0) ||
                 (timer == period - P_ONE));
  assign req  = trig | single;

  // Period timer: free-runs while enabled, cleared when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (!enable || trig) begin
      timer <= '0;
    end else begin
      timer <= timer + P_ONE;
    end
  end

  // Conversion FSM with registered go/busy and timeout detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      go_r        <= 1'b0;
      busy        <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
      cap         <= '0;
      timeout_err <= 1'b0;
    end else begin
      pending <= pending | req;
      if (clr_err) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (pending) begin
            state   <= S_START;
            pending <= req;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          state <= S_WAIT;
          go_r  <= 1'b1;
          tcnt  <= '0;
        end
        S_WAIT: begin
          if (bus.valid) begin
            state <= S_CAP;
            cap   <= bus.result;
          end else if (tcnt == T_LAST) begin
            state       <= S_GAP;
            go_r        <= 1'b0;
            gcnt        <= '0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        S_CAP: begin
          state <= S_GAP;
          go_r  <= 1'b0;
          gcnt  <= '0;
        end
        S_GAP: begin
          if (gcnt == G_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + G_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          go_r  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.go = go_r;

  // A pop makes room for a write landing in the same cycle.
  assign wr        = (state == S_CAP);
  assign fifo_full = (cnt == C_FULL);
  assign do_rd     = bus.rd_en && (cnt != '0);
  assign do_wr     = wr && (!fifo_full || do_rd);
  assign drop      = wr && fifo_full && !do_rd;

  // Result storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= cap;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + A_ONE;
      end
      if (do_rd) begin
        rptr <= rptr + A_ONE;
      end
      if (do_wr && !do_rd) begin
        cnt <= cnt + C_ONE;
      end else if (do_rd && !do_wr) begin
        cnt <= cnt - C_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.rd_data = mem[rptr];
  assign bus.empty   = (cnt == '0);
  assign bus.full    = fifo_full;
  assign bus.count   = cnt;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer:
// SAR controller model, FIFO scoreboard, vector table.
module tb_sar_conv_sequencer;

  localparam int DW    = 8;
  localparam int PW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] period;
  logic          single;
  logic          clr_err;
  logic          busy;
  logic          overflow;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sar_conv_sequencer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  sar_conv_sequencer #(
    .DATA_W(DW), .PERIOD_W(PW), .FIFO_DEPTH(DEPTH),
    .TIMEOUT(32), .GAP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .period(period),
    .single(single),
    .clr_err(clr_err),
    .busy(busy),
    .overflow(overflow),
    .timeout_err(timeout_err),
    .bus(bus)
  );

  // SAR controller model and scoreboard
  int          lat;
  logic [7:0]  res_base;
  logic        force_v;
  logic        valid_m;
  logic        vq;
  logic        st1;
  logic        go_q;
  logic [7:0]  res_m;
  logic [7:0]  v1;
  int          lcnt;
  int          conv_n;
  int          gorise;
  logic [7:0]  sbq [$];

  assign bus.valid  = valid_m | force_v;
  assign bus.result = force_v ? 8'hEE : res_m;

  always @(posedge clk) begin
    if (rst) begin
      valid_m <= 1'b0;
      vq      <= 1'b0;
      st1     <= 1'b0;
      go_q    <= 1'b0;
      lcnt    <= 0;
      conv_n  <= 0;
      gorise  <= 0;
      sbq.delete();
    end else begin
      go_q <= bus.go;
      if (bus.go && !go_q) gorise <= gorise + 1;
      if (!bus.go) begin
        valid_m <= 1'b0;
        lcnt    <= 0;
      end else if (!valid_m) begin
        if (lcnt == lat - 1) begin
          valid_m <= 1'b1;
          res_m   <= res_base + 8'(conv_n);
          conv_n  <= conv_n + 1;
        end else begin
          lcnt <= lcnt + 1;
        end
      end
      vq  <= valid_m;
      st1 <= valid_m && !vq;
      v1  <= res_m;
      if (bus.rd_en && sbq.size() > 0) void'(sbq.pop_front());
      if (st1 && sbq.size() < DEPTH) sbq.push_back(v1);
    end
  end

  typedef struct {
    bit          periodic;
    logic [15:0] per;
    int          lat;
    logic [7:0]  base;
    int          n;
    int          exp_cnt;
    bit          exp_ovf;
    bit          exp_terr;
  } row_t;

  row_t rows [5];

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    enable     = 1'b0;
    single     = 1'b0;
    clr_err    = 1'b0;
    bus.rd_en  = 1'b0;
    force_v    = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_single;
    single = 1'b1;
    tick(1);
    single = 1'b0;
  endtask

  task automatic read_one;
    chk("empty_before_pop", 32'(bus.empty), 32'd0);
    if (sbq.size() == 0) begin
      chk("sb_has_entry", 32'(sbq.size()), 32'd1);
    end else begin
      chk("rd_data", 32'(bus.rd_data), 32'(sbq[0]));
    end
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_go(input logic lvl, input string nm);
    for (int i = 0; i < 300 && bus.go !== lvl; i++) tick(1);
    chk(nm, 32'(bus.go), 32'(lvl));
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick(1);
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int stop;
    bit done;

    rows[0] = '{1'b0, 16'd0,  11,   8'hA5, 1, 1, 1'b0, 1'b0};
    rows[1] = '{1'b1, 16'd20, 11,   8'h01, 5, 5, 1'b0, 1'b0};
    rows[2] = '{1'b1, 16'd0,  3,    8'h01, 9, 8, 1'b1, 1'b0};
    rows[3] = '{1'b0, 16'd0,  1000, 8'h00, 1, 0, 1'b0, 1'b1};
    rows[4] = '{1'b1, 16'd0,  5,    8'h40, 3, 3, 1'b0, 1'b0};

    rst = 1'b1;
    enable = 1'b0;
    period = '0;
    single = 1'b0;
    clr_err = 1'b0;
    bus.rd_en = 1'b0;
    force_v = 1'b0;
    lat = 11;
    res_base = 8'h00;
    tick(1);
    do_reset;

    chk("rst_go", 32'(bus.go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);

    for (int r = 0; r < 5; r++) begin
      do_reset;
      lat      = rows[r].lat;
      res_base = rows[r].base;
      period   = rows[r].per;
      stop     = rows[r].n - ((rows[r].per == 0) ? 1 : 0);
      if (rows[r].periodic) enable = 1'b1;
      else pulse_single;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        tick(1);
        if (gorise >= stop) enable = 1'b0;
        if (gorise >= rows[r].n && busy === 1'b0) done = 1'b1;
      end
      chk("row_done", 32'(done), 32'd1);
      tick(4);
      chk("row_gorise", 32'(gorise), 32'(rows[r].n));
      chk("row_count", 32'(bus.count), 32'(rows[r].exp_cnt));
      chk("row_ovf", 32'(overflow), 32'(rows[r].exp_ovf));
      chk("row_terr", 32'(timeout_err), 32'(rows[r].exp_terr));
      chk("row_full", 32'(bus.full),
          32'(rows[r].exp_cnt == DEPTH));
      for (int k = 0; k < rows[r].exp_cnt; k++) read_one;
      chk("row_empty", 32'(bus.empty), 32'd1);
    end

    // single-shot timing
    do_reset;
    lat = 11;
    res_base = 8'hA5;
    pulse_single;
    tick(1);
    chk("go_low_1", 32'(bus.go), 32'd0);
    tick(1);
    chk("go_rise_2", 32'(bus.go), 32'd1);
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.go === 1'b1) hi++;
      else break;
    end
    chk("go_hi_cycles", 32'(hi), 32'd13);
    chk("cap_count", 32'(bus.count), 32'd1);
    chk("cap_rd_data", 32'(bus.rd_data), 32'hA5);
    chk("gap_busy_0", 32'(busy), 32'd1);
    tick(1);
    chk("gap_go_1", 32'(bus.go), 32'd0);
    chk("gap_busy_1", 32'(busy), 32'd1);
    tick(1);
    chk("idle_busy", 32'(busy), 32'd0);
    read_one;

    // triggers while busy collapse to one extra conversion
    do_reset;
    lat = 11;
    res_base = 8'h10;
    pulse_single;
    tick(5);
    pulse_single;
    period = 16'd5;
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (gorise >= 2 && busy === 1'b0) break;
      tick(1);
    end
    tick(30);
    chk("collapse_gorise", 32'(gorise), 32'd2);
    chk("collapse_count", 32'(bus.count), 32'd2);
    read_one;
    read_one;

    // full FIFO with pop on the write edge, then overflow, clr_err
    do_reset;
    lat = 3;
    res_base = 8'h20;
    period = '0;
    enable = 1'b1;
    for (int i = 0; i < 500 && bus.count != 4'(DEPTH); i++) tick(1);
    enable = 1'b0;
    chk("fill_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 200 && !(valid_m && !vq); i++) tick(1);
    chk("sim_valid_seen", 32'(valid_m && !vq), 32'd1);
    tick(1);
    chk("sim_rd_data", 32'(bus.rd_data), 32'(sbq[0]));
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    chk("sim_count", 32'(bus.count), 32'd8);
    chk("sim_ovf", 32'(overflow), 32'd0);
    wait_idle("sim_idle");
    pulse_single;
    for (int i = 0; i < 300 && overflow !== 1'b1; i++) tick(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd8);
    tick(1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    for (int k = 0; k < DEPTH; k++) read_one;
    chk("ovf_drained", 32'(bus.empty), 32'd1);

    // timeout, restart, reset mid-WAIT
    do_reset;
    lat = 1000;
    pulse_single;
    wait_go(1'b1, "to_go_rise");
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.go === 1'b1) hi++;
      else break;
    end
    chk("to_go_cycles", 32'(hi), 32'd32);
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_count", 32'(bus.count), 32'd0);
    wait_idle("to_idle");
    lat = 20;
    res_base = 8'h77;
    pulse_single;
    wait_go(1'b1, "restart_go");
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_go", 32'(bus.go), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_terr", 32'(timeout_err), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    force_v = 1'b1;
    tick(3);
    force_v = 1'b0;
    tick(3);
    chk("late_valid_count", 32'(bus.count), 32'd0);
    chk("late_valid_go", 32'(bus.go), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
